// File: rtl/regbank_port_ctrl_if.sv
// CPU-side request/response bundle for regbank_port_ctrl.
// master = datapath issuing reads/writes, slave = the port controller.
interface regbank_port_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              rd_rsp_valid;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              wr_req_valid;
  logic              wr_req_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output rd_req_valid, rd_addr1, rd_addr2, wr_req_valid, wr_addr, wr_data,
    input  rd_req_ready, rd_rsp_valid, rd_data1, rd_data2, wr_req_ready
  );

  modport slave (
    input  rd_req_valid, rd_addr1, rd_addr2, wr_req_valid, wr_addr, wr_data,
    output rd_req_ready, rd_rsp_valid, rd_data1, rd_data2, wr_req_ready
  );
endinterface

// File: rtl/regbank_port_ctrl.sv
// Register-bank port controller: operand reads with bank settling wait, posted writes with forwarding.
// Optional REGPORT_XZR_EN makes index 31 a hard-wired zero register.
module regbank_port_ctrl #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 5,
  parameter int READ_WAIT  = 2,
  parameter int WBUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  regbank_port_ctrl_if.slave bus,
  output logic [ADDR_W-1:0] rb_read_register1,
  output logic [ADDR_W-1:0] rb_read_register2,
  input  logic [DATA_W-1:0] rb_read_data1,
  input  logic [DATA_W-1:0] rb_read_data2,
  output logic [ADDR_W-1:0] rb_write_register,
  output logic [DATA_W-1:0] rb_write_data,
  output logic              rb_write,
  output logic              busy,
  output logic [1:0]        dbg_state
);
  localparam int PTR_W  = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CNT_W  = $clog2(WBUF_DEPTH + 1);
  localparam int WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(WBUF_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WBUF_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_WAIT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, RD_DONE = 2'd2, WR = 2'd3} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] wb_addr [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data [WBUF_DEPTH];
  logic [PTR_W-1:0]  wb_head, wb_tail;
  logic [CNT_W-1:0]  wb_count;
  logic              wb_full, wb_empty;
  logic              rd_hs, wr_hs, push, pop;
  logic [WAIT_W-1:0] wait_cnt;
  logic              fwd_hit1, fwd_hit2, fwd_hit1_q, fwd_hit2_q;
  logic [DATA_W-1:0] fwd_data1, fwd_data2, fwd_data1_q, fwd_data2_q;
  logic              zero1, zero2, zero1_q, zero2_q;
  int                age, best1, best2;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Handshakes: a request transfers on the clock edge where valid && ready are both 1;
  // valid and payload must hold until then; ready never depends combinationally on valid.
  assign wb_full          = (wb_count == CNT_FULL);
  assign wb_empty         = (wb_count == '0);
  assign bus.rd_req_ready = !rst && (state == IDLE) && !wb_full;
  assign bus.wr_req_ready = !rst && !wb_full;
  assign rd_hs            = bus.rd_req_valid && bus.rd_req_ready;
  assign wr_hs            = bus.wr_req_valid && bus.wr_req_ready;
  assign pop              = !rst && (state == WR);
  assign rb_write         = pop;
  assign bus.rd_rsp_valid = !rst && (state == RD_DONE);
  assign busy             = !rst && ((state != IDLE) || !wb_empty);
  assign dbg_state        = state;

`ifdef REGPORT_XZR_EN
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);
  assign push  = wr_hs && (bus.wr_addr != ZERO_REG);
  assign zero1 = (bus.rd_addr1 == ZERO_REG);
  assign zero2 = (bus.rd_addr2 == ZERO_REG);
`else
  assign push  = wr_hs;
  assign zero1 = 1'b0;
  assign zero2 = 1'b0;
`endif

  // Forwarding scan: age 0 is the head (oldest); the largest matching age is the newest write.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    best1     = -1;
    best2     = -1;
    age       = 0;
    for (int j = 0; j < WBUF_DEPTH; j++) begin
      age = (j >= int'(wb_head)) ? j - int'(wb_head) : j + WBUF_DEPTH - int'(wb_head);
      if (age < int'(wb_count)) begin
        if (wb_addr[j] == bus.rd_addr1 && age > best1) begin
          best1 = age; fwd_hit1 = 1'b1; fwd_data1 = wb_data[j];
        end
        if (wb_addr[j] == bus.rd_addr2 && age > best2) begin
          best2 = age; fwd_hit2 = 1'b1; fwd_data2 = wb_data[j];
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rd_hs) state_nxt = RD_WAIT;
               else if (!wb_empty) state_nxt = WR;
      RD_WAIT: if (wait_cnt == WAIT_LAST) state_nxt = RD_DONE;
      RD_DONE: state_nxt = IDLE;
      WR:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wb_addr[wb_tail] <= bus.wr_addr;
      wb_data[wb_tail] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      wb_head           <= '0;
      wb_tail           <= '0;
      wb_count          <= '0;
      rb_read_register1 <= '0;
      rb_read_register2 <= '0;
      rb_write_register <= '0;
      rb_write_data     <= '0;
      bus.rd_data1      <= '0;
      bus.rd_data2      <= '0;
      fwd_hit1_q        <= 1'b0;
      fwd_hit2_q        <= 1'b0;
      fwd_data1_q       <= '0;
      fwd_data2_q       <= '0;
      zero1_q           <= 1'b0;
      zero2_q           <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wb_tail <= ptr_inc(wb_tail);
      if (pop)  wb_head <= ptr_inc(wb_head);
      case ({push, pop})
        2'b10:   wb_count <= wb_count + 1'b1;
        2'b01:   wb_count <= wb_count - 1'b1;
        default: wb_count <= wb_count;
      endcase
      // Forwarding is resolved against the buffer as it stood at acceptance.
      if (rd_hs) begin
        rb_read_register1 <= bus.rd_addr1;
        rb_read_register2 <= bus.rd_addr2;
        fwd_hit1_q        <= fwd_hit1;
        fwd_hit2_q        <= fwd_hit2;
        fwd_data1_q       <= fwd_data1;
        fwd_data2_q       <= fwd_data2;
        zero1_q           <= zero1;
        zero2_q           <= zero2;
        wait_cnt          <= '0;
      end else if (state == RD_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == RD_WAIT && wait_cnt == WAIT_LAST) begin
        bus.rd_data1 <= zero1_q ? '0 : (fwd_hit1_q ? fwd_data1_q : rb_read_data1);
        bus.rd_data2 <= zero2_q ? '0 : (fwd_hit2_q ? fwd_data2_q : rb_read_data2);
      end
      if (state == IDLE && state_nxt == WR) begin
        rb_write_register <= wb_addr[wb_head];
        rb_write_data     <= wb_data[wb_head];
      end
    end
  end
endmodule

// File: tb/tb_regbank_port_ctrl.sv
// Directed bench for regbank_port_ctrl with a 32x64 bank model whose entry i resets to i.
// Build with REGPORT_XZR_EN defined to exercise the zero-register variant.
module tb_regbank_port_ctrl;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regbank_port_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();
  logic [ADDR_W-1:0] rb_read_register1, rb_read_register2, rb_write_register;
  logic [DATA_W-1:0] rb_read_data1, rb_read_data2, rb_write_data;
  logic              rb_write, busy;
  logic [1:0]        dbg_state;

  regbank_port_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_WAIT(2), .WBUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rb_read_register1(rb_read_register1), .rb_read_register2(rb_read_register2),
    .rb_read_data1(rb_read_data1), .rb_read_data2(rb_read_data2),
    .rb_write_register(rb_write_register), .rb_write_data(rb_write_data),
    .rb_write(rb_write), .busy(busy), .dbg_state(dbg_state)
  );

  // Bank model and event monitors
  logic [DATA_W-1:0] bank [32];
  logic bank_init = 1'b1;
  int wr_pulses = 0;
  int rsp_pulses = 0;
  always @(posedge clk) begin
    if (bank_init) for (int i = 0; i < 32; i++) bank[i] <= DATA_W'(i);
    else if (rb_write) bank[rb_write_register] <= rb_write_data;
  end
  always @(posedge clk) begin
    if (rb_write) wr_pulses++;
    if (bus.rd_rsp_valid) rsp_pulses++;
  end
  assign rb_read_data1 = bank[rb_read_register1];
  assign rb_read_data2 = bank[rb_read_register2];

  int n_checks = 0;
  int n_pass = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, output logic ok);
    int n = 0;
    ok = 1'b0;
    bus.wr_req_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    while (!ok && n < 40) begin
      @(negedge clk); ok = bus.wr_req_ready; tick(); n++;
    end
    bus.wr_req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2, output logic ok,
                         output int lat, output logic [DATA_W-1:0] d1, output logic [DATA_W-1:0] d2);
    logic acc = 1'b0;
    int n = 0;
    ok = 1'b0; lat = 0; d1 = '0; d2 = '0;
    bus.rd_req_valid = 1'b1; bus.rd_addr1 = a1; bus.rd_addr2 = a2;
    while (!acc && n < 40) begin
      @(negedge clk); acc = bus.rd_req_ready; tick(); n++;
    end
    bus.rd_req_valid = 1'b0;
    if (acc) begin
      lat = 1;
      while (!ok && lat < 40) begin
        @(negedge clk);
        if (bus.rd_rsp_valid) begin ok = 1'b1; d1 = bus.rd_data1; d2 = bus.rd_data2; end
        tick();
        if (!ok) lat++;
      end
    end
  endtask

  task automatic test_reset();
    tick();
    bank_init = 1'b0;
    @(negedge clk);
    n_checks++; if ({bus.rd_req_ready, bus.wr_req_ready, bus.rd_rsp_valid, rb_write, busy} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {bus.rd_req_ready, bus.wr_req_ready, bus.rd_rsp_valid, rb_write, busy}); else n_pass++;
    n_checks++; if ({bus.rd_data1, bus.rd_data2, rb_write_data} !== '0)
      $display("FAIL reset_data: got %h %h %h want 0", bus.rd_data1, bus.rd_data2, rb_write_data); else n_pass++;
    n_checks++; if ({rb_read_register1, rb_read_register2, rb_write_register, dbg_state} !== '0)
      $display("FAIL reset_regs: got %h %h %h st %0d want 0", rb_read_register1, rb_read_register2, rb_write_register, dbg_state); else n_pass++;
    rst = 1'b0;
    tick();
    @(negedge clk);
    n_checks++; if ({bus.rd_req_ready, bus.wr_req_ready, busy} !== 3'b110)
      $display("FAIL post_reset_ready: got %b want 110", {bus.rd_req_ready, bus.wr_req_ready, busy}); else n_pass++;
    tick();
  endtask

  task automatic test_read_basic();
    bus.rd_req_valid = 1'b1; bus.rd_addr1 = 5'd3; bus.rd_addr2 = 5'd7;
    @(negedge clk);
    n_checks++; if (bus.rd_req_ready !== 1'b1) $display("FAIL t1_ready: got %b want 1", bus.rd_req_ready); else n_pass++;
    tick();
    bus.rd_req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({rb_read_register1, rb_read_register2} !== {5'd3, 5'd7})
      $display("FAIL t1_bank_addr: got %0d,%0d want 3,7", rb_read_register1, rb_read_register2); else n_pass++;
    n_checks++; if ({bus.rd_rsp_valid, busy} !== 2'b01) $display("FAIL t1_rsp_t1: got rsp/busy %b want 01", {bus.rd_rsp_valid, busy}); else n_pass++;
    tick(); @(negedge clk);
    n_checks++; if (bus.rd_rsp_valid !== 1'b0) $display("FAIL t1_rsp_t2: got %b want 0", bus.rd_rsp_valid); else n_pass++;
    tick(); @(negedge clk);
    n_checks++; if (bus.rd_rsp_valid !== 1'b1) $display("FAIL t1_rsp_t3: got %b want 1", bus.rd_rsp_valid); else n_pass++;
    n_checks++; if ({bus.rd_data1, bus.rd_data2} !== {64'd3, 64'd7})
      $display("FAIL t1_data: got %h,%h want 3,7", bus.rd_data1, bus.rd_data2); else n_pass++;
    tick(); @(negedge clk);
    n_checks++; if ({bus.rd_rsp_valid, busy, bus.rd_data1} !== {2'b00, 64'd3})
      $display("FAIL t1_after: got rsp %b busy %b d1 %h want 0 0 3", bus.rd_rsp_valid, busy, bus.rd_data1); else n_pass++;
    tick();
  endtask

  task automatic test_forward();
    logic ok_w, ok_r; int lat; logic [DATA_W-1:0] d1, d2;
    do_write(5'd5, 64'hAA, ok_w);
    do_read(5'd5, 5'd5, ok_r, lat, d1, d2);
    n_checks++; if ({ok_w, ok_r, lat} !== {2'b11, 32'd3}) $display("FAIL fwd_lat: got ok %b%b lat %0d want 11 3", ok_w, ok_r, lat); else n_pass++;
    n_checks++; if ({d1, d2} !== {64'hAA, 64'hAA}) $display("FAIL fwd_data: got %h,%h want aa,aa", d1, d2); else n_pass++;
    repeat (4) tick();
    n_checks++; if (bank[5] !== 64'hAA) $display("FAIL fwd_drain: got bank[5]=%h want aa", bank[5]); else n_pass++;
  endtask

  task automatic test_newest_wins();
    logic ok_a, ok_b, ok_r; int lat; logic [DATA_W-1:0] d1, d2;
    wr_pulses = 0;
    do_write(5'd9, 64'h11, ok_a);
    do_write(5'd9, 64'h22, ok_b);
    do_read(5'd9, 5'd9, ok_r, lat, d1, d2);
    n_checks++; if ({ok_a, ok_b, ok_r, d1, d2} !== {3'b111, 64'h22, 64'h22})
      $display("FAIL newest_data: got ok %b%b%b %h,%h want 111 22,22", ok_a, ok_b, ok_r, d1, d2); else n_pass++;
    repeat (4) tick();
    n_checks++; if (bank[9] !== 64'h22) $display("FAIL newest_bank: got %h want 22", bank[9]); else n_pass++;
    n_checks++; if (wr_pulses !== 2) $display("FAIL newest_pulses: got %0d want 2", wr_pulses); else n_pass++;
  endtask

  task automatic test_full_stall();
    int lat = 0; logic got = 1'b0;
    bus.rd_req_valid = 1'b1; bus.rd_addr1 = 5'd20; bus.rd_addr2 = 5'd21;
    bus.wr_req_valid = 1'b1; bus.wr_addr = 5'd20; bus.wr_data = 64'h100;
    @(negedge clk);
    n_checks++; if ({bus.rd_req_ready, bus.wr_req_ready} !== 2'b11) $display("FAIL full_a0: got %b want 11", {bus.rd_req_ready, bus.wr_req_ready}); else n_pass++;
    tick();
    bus.wr_addr = 5'd21; bus.wr_data = 64'h200;
    @(negedge clk);
    n_checks++; if ({bus.rd_req_ready, bus.wr_req_ready} !== 2'b01) $display("FAIL full_a1: got %b want 01", {bus.rd_req_ready, bus.wr_req_ready}); else n_pass++;
    tick();
    bus.wr_req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({bus.rd_req_ready, bus.wr_req_ready} !== 2'b00) $display("FAIL full_a2: got %b want 00", {bus.rd_req_ready, bus.wr_req_ready}); else n_pass++;
    tick(); @(negedge clk);
    n_checks++; if ({bus.rd_rsp_valid, bus.rd_req_ready, bus.rd_data1, bus.rd_data2} !== {2'b10, 64'd20, 64'd21})
      $display("FAIL full_rsp: got rsp %b rdy %b %h,%h want 1 0 14,15", bus.rd_rsp_valid, bus.rd_req_ready, bus.rd_data1, bus.rd_data2); else n_pass++;
    tick(); @(negedge clk);
    n_checks++; if ({bus.rd_req_ready, rb_write} !== 2'b00) $display("FAIL full_a4: got %b want 00", {bus.rd_req_ready, rb_write}); else n_pass++;
    tick(); @(negedge clk);
    n_checks++; if ({rb_write, bus.rd_req_ready, rb_write_register, rb_write_data} !== {2'b10, 5'd20, 64'h100})
      $display("FAIL full_drain: got wr %b rdy %b reg %0d data %h want 1 0 20 100", rb_write, bus.rd_req_ready, rb_write_register, rb_write_data); else n_pass++;
    tick(); @(negedge clk);
    n_checks++; if ({bus.rd_req_ready, bus.wr_req_ready, rb_write} !== 3'b110) $display("FAIL full_a6: got %b want 110", {bus.rd_req_ready, bus.wr_req_ready, rb_write}); else n_pass++;
    tick();
    bus.rd_req_valid = 1'b0;
    while (!got && lat < 40) begin
      lat++;
      @(negedge clk);
      if (bus.rd_rsp_valid) begin
        got = 1'b1;
        n_checks++; if ({lat, bus.rd_data1, bus.rd_data2} !== {32'd3, 64'h100, 64'h200})
          $display("FAIL full_second_read: got lat %0d %h,%h want 3 100,200", lat, bus.rd_data1, bus.rd_data2); else n_pass++;
      end
      tick();
    end
    n_checks++; if (got !== 1'b1) $display("FAIL full_second_timeout: got %b want 1", got); else n_pass++;
    repeat (4) tick();
    n_checks++; if (bank[21] !== 64'h200) $display("FAIL full_bank21: got %h want 200", bank[21]); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    rsp_pulses = 0; wr_pulses = 0;
    bus.rd_req_valid = 1'b1; bus.rd_addr1 = 5'd1; bus.rd_addr2 = 5'd2;
    tick();
    bus.rd_req_valid = 1'b0;
    bus.wr_req_valid = 1'b1; bus.wr_addr = 5'd12; bus.wr_data = 64'h55;
    tick();
    bus.wr_req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({bus.rd_rsp_valid, rb_write, busy, dbg_state} !== 5'b0)
      $display("FAIL rst_mid_flags: got rsp %b wr %b busy %b st %0d want 0", bus.rd_rsp_valid, rb_write, busy, dbg_state); else n_pass++;
    n_checks++; if ({bus.rd_data1, bus.rd_data2, rb_read_register1, rb_write_register, rb_write_data} !== '0)
      $display("FAIL rst_mid_data: got %h %h %0d %0d %h want 0", bus.rd_data1, bus.rd_data2, rb_read_register1, rb_write_register, rb_write_data); else n_pass++;
    repeat (6) tick();
    n_checks++; if ({rsp_pulses, wr_pulses} !== {32'd0, 32'd0}) $display("FAIL rst_mid_events: got rsp %0d wr %0d want 0 0", rsp_pulses, wr_pulses); else n_pass++;
    n_checks++; if (bank[12] !== 64'd12) $display("FAIL rst_mid_bank12: got %h want c", bank[12]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic ok; int lat; logic [DATA_W-1:0] d1, d2;
    rsp_pulses = 0;
    exp_q.push_back(64'd1); exp_q.push_back(64'd2); exp_q.push_back(64'd30); exp_q.push_back(64'd31);
    do_read(5'd1, 5'd2, ok, lat, d1, d2);
    n_checks++; if ({ok, lat} !== {1'b1, 32'd3}) $display("FAIL b2b_first_lat: got ok %b lat %0d want 1 3", ok, lat); else n_pass++;
    n_checks++; if (d1 !== exp_q[0] || d2 !== exp_q[1]) $display("FAIL b2b_first_data: got %h,%h want %h,%h", d1, d2, exp_q[0], exp_q[1]); else n_pass++;
    void'(exp_q.pop_front()); void'(exp_q.pop_front());
    do_read(5'd30, 5'd31, ok, lat, d1, d2);
    n_checks++; if ({ok, lat} !== {1'b1, 32'd3}) $display("FAIL b2b_second_lat: got ok %b lat %0d want 1 3", ok, lat); else n_pass++;
    n_checks++; if (d1 !== exp_q[0] || d2 !== exp_q[1]) $display("FAIL b2b_second_data: got %h,%h want %h,%h", d1, d2, exp_q[0], exp_q[1]); else n_pass++;
    void'(exp_q.pop_front()); void'(exp_q.pop_front());
    n_checks++; if (rsp_pulses !== 2) $display("FAIL b2b_pulses: got %0d want 2", rsp_pulses); else n_pass++;
  endtask

  task automatic test_reg31();
    logic ok_w, ok_r; int lat; logic [DATA_W-1:0] d1, d2;
    wr_pulses = 0;
    do_write(5'd31, 64'hFF, ok_w);
    do_read(5'd31, 5'd4, ok_r, lat, d1, d2);
    repeat (4) tick();
    n_checks++; if ({ok_w, ok_r} !== 2'b11) $display("FAIL r31_handshake: got %b want 11", {ok_w, ok_r}); else n_pass++;
`ifdef REGPORT_XZR_EN
    n_checks++; if ({d1, d2} !== {64'd0, 64'd4}) $display("FAIL xzr_data: got %h,%h want 0,4", d1, d2); else n_pass++;
    n_checks++; if (wr_pulses !== 0) $display("FAIL xzr_no_write: got %0d want 0", wr_pulses); else n_pass++;
`else
    n_checks++; if ({d1, d2} !== {64'hFF, 64'd4}) $display("FAIL r31_data: got %h,%h want ff,4", d1, d2); else n_pass++;
    n_checks++; if ({wr_pulses, bank[31]} !== {32'd1, 64'hFF}) $display("FAIL r31_write: got %0d pulses bank %h want 1 ff", wr_pulses, bank[31]); else n_pass++;
`endif
  endtask

  initial begin
    bus.rd_req_valid = 1'b0; bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    bus.wr_req_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    test_reset();
    test_read_basic();
    test_forward();
    test_newest_wins();
    test_full_stall();
    test_reset_mid_read();
    test_back_to_back();
    test_reg31();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
